muldiv_iter_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide engine that replaces the fixed 32-bit mult/div sub-blocks inside the ALU.
- Produces HI/LO results of width WIDTH.
- Uses a start/busy/done handshake with a bus-stall hold and a pipeline flush (exception) abort.
- Sits in EX stage, writes HI/LO via the existing writeback path.

---
 rtl/muldiv_iter_unit.sv | 201 ++++++++++++++++++++
 tb/tb_muldiv_iter_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter_unit.sv
// Iterative multiply/divide engine producing HI/LO results.
// Multiply: magnitude product through MUL_LAT register stages, sign fixed at completion.
// Divide: restoring algorithm, one quotient bit per clock, sign fixed at completion.
module muldiv_iter_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             stall,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic             a_neg_q, a_neg_d;      // sign of dividend / operand A (signed ops only)
    logic             res_neg_q, res_neg_d;  // product / quotient must be negated
    logic             dbz_pend_q, dbz_pend_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             op_signed;
    logic [WIDTH-1:0] a_mag_in, b_mag_in;
    logic [2*WIDTH-1:0] prod_full, prod_last, prod_signed;
    logic [WIDTH:0]   div_shift, div_trial;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic [WIDTH-1:0] fix_rem, fix_quo, raw_a;

    assign accept    = start && !flush && ((state_q == S_IDLE) || (state_q == S_DONE && !stall));
    assign op_signed = !op[0];
    assign a_mag_in  = (op_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag_in  = (op_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Product pipeline: the last stage is the hi/lo register itself, so MUL_LAT-1 stages here
    assign prod_full = {{WIDTH{1'b0}}, mag_a_q} * {{WIDTH{1'b0}}, mag_b_q};

    genvar gi;
    generate
        if (MUL_LAT == 1) begin : g_nopipe
            assign prod_last = prod_full;
        end else begin : g_pipe
            for (gi = 0; gi < MUL_LAT - 1; gi++) begin : g_stage
                logic [2*WIDTH-1:0] stage_q, stage_d;
                if (gi == 0) begin : g_first
                    // First stage samples the raw magnitude product
                    always_comb stage_d = prod_full;
                end else begin : g_next
                    // Later stages just forward the previous stage
                    always_comb stage_d = g_stage[gi-1].stage_q;
                end
                // Stage register, free-running
                always_ff @(posedge clk) begin
                    if (rst) stage_q <= '0;
                    else     stage_q <= stage_d;
                end
            end
            assign prod_last = g_stage[MUL_LAT-2].stage_q;
        end
    endgenerate

    assign prod_signed = res_neg_q ? (~prod_last + 1'b1) : prod_last;

    // One restoring-division step; remainder stays below the divisor so WIDTH+1 bits suffice
    assign div_shift = {rem_q, quo_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, mag_b_q};
    assign step_rem  = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
    assign step_quo  = {quo_q[WIDTH-2:0], !div_trial[WIDTH]};
    assign fix_quo   = res_neg_q ? (~step_quo + 1'b1) : step_quo;
    assign fix_rem   = a_neg_q ? (~step_rem + 1'b1) : step_rem;
    assign raw_a     = a_neg_q ? (~mag_a_q + 1'b1) : mag_a_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = op[1] ? S_DIV : S_MUL;
            S_MUL, S_DIV: begin
                if (flush)              state_d = S_IDLE;
                else if (cnt_q == '0)   state_d = S_DONE;
            end
            S_DONE: begin
                if (flush)              state_d = S_IDLE;
                else if (!stall)        state_d = accept ? (op[1] ? S_DIV : S_MUL) : S_IDLE;
            end
            default:                    state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state_q == S_MUL) || (state_q == S_DIV);
        done = (state_q == S_DONE);
    end

    // Operand latching, iteration and result capture
    always_comb begin
        cnt_d      = cnt_q;
        mag_a_d    = mag_a_q;
        mag_b_d    = mag_b_q;
        a_neg_d    = a_neg_q;
        res_neg_d  = res_neg_q;
        dbz_pend_d = dbz_pend_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dbz_d      = dbz_q;
        if (accept) begin
            mag_a_d    = a_mag_in;
            mag_b_d    = b_mag_in;
            a_neg_d    = op_signed && a[WIDTH-1];
            res_neg_d  = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            dbz_pend_d = op[1] && (b == '0);
            rem_d      = '0;
            quo_d      = a_mag_in;
            dbz_d      = 1'b0;
            if (!op[1])        cnt_d = CW'(MUL_LAT - 1);
            else if (b == '0)  cnt_d = '0;
            else               cnt_d = CW'(WIDTH - 1);
        end else if (!flush && state_q == S_MUL) begin
            if (cnt_q == '0) begin
                hi_d = prod_signed[2*WIDTH-1:WIDTH];
                lo_d = prod_signed[WIDTH-1:0];
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (!flush && state_q == S_DIV) begin
            if (dbz_pend_q) begin
                hi_d  = raw_a;
                lo_d  = '1;
                dbz_d = 1'b1;
            end else begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == '0) begin
                    hi_d = fix_rem;
                    lo_d = fix_quo;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            a_neg_q    <= 1'b0;
            res_neg_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            rem_q      <= '0;
            quo_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            dbz_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            mag_a_q    <= mag_a_d;
            mag_b_q    <= mag_b_d;
            a_neg_q    <= a_neg_d;
            res_neg_q  <= res_neg_d;
            dbz_pend_q <= dbz_pend_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dbz_q      <= dbz_d;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Self-checking bench for muldiv_iter_unit: directed table, random ops against
// an arithmetic reference model, and stall / flush / reset sequences.
module tb_muldiv_iter_unit;
    localparam int W   = 32;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst, start, stall, flush;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int pass_cnt  = 0;
    int total_cnt = 0;

    muldiv_iter_unit #(.WIDTH(W), .MUL_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .stall(stall), .flush(flush), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // Reference: plain integer arithmetic, returns {dbz, hi, lo}
    function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint          sx, sy, sp, sq, sr;
        longint unsigned up;
        logic [W-1:0]    uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: begin sp = sx * sy; return {1'b0, sp[2*W-1:0]}; end
            2'd1: begin up = {32'b0, x} * {32'b0, y}; return {1'b0, up[2*W-1:0]}; end
            default: begin
                if (y == '0) return {1'b1, x, {W{1'b1}}};
                if (o == 2'd2) begin
                    sq = sx / sy;
                    sr = sx % sy;
                    return {1'b0, sr[W-1:0], sq[W-1:0]};
                end
                uq = x / y;
                ur = x % y;
                return {1'b0, ur, uq};
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [W-1:0] y);
        if (!o[1]) return LAT + 1;
        if (y == '0) return 2;
        return W + 1;
    endfunction

    // Present a request and let the accept edge pass; afterwards scramble the inputs
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    // Count cycles (sampled at negedge) until done; busy must hold on every cycle before it
    task automatic wait_done(output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (done) return;
            if (!busy) busy_ok = 1'b0;
        end
        lat = -1;
    endtask

    task automatic do_op(input string nm, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz, input int elat);
        int lat;
        bit bok;
        issue(o, x, y);
        wait_done(lat, bok);
        $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0b lat=%0d", nm, o, x, y, hi, lo, div_by_zero, lat);
        check({nm, " latency"}, 64'(lat), 64'(elat));
        check({nm, " busy"},    64'(bok), 64'd1);
        check({nm, " hi"},      64'(hi),  64'(ehi));
        check({nm, " lo"},      64'(lo),  64'(elo));
        check({nm, " dbz"},     64'(div_by_zero), 64'(edbz));
        @(negedge clk);
        check({nm, " done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int lat;
        bit bok;
        bit seen;
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        logic [2*W:0] exp;

        vecs[0] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 3};
        vecs[1] = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 3};
        vecs[2] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[3] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
        vecs[4] = '{2'd3, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 2};
        vecs[5] = '{2'd1, 32'h00000005, 32'h00000006, 32'h00000000, 32'h0000001E, 1'b0, 3};
        vecs[6] = '{2'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 33};
        vecs[7] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 3};
        vecs[8] = '{2'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 2};

        rst = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi",   64'(hi),   64'd0);
        check("reset lo",   64'(lo),   64'd0);
        check("reset dbz",  64'(div_by_zero), 64'd0);

        // Directed table
        for (int i = 0; i < 9; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].lat);

        // Random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 15));
                2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                default: ;
            endcase
            exp = model(ro, ra, rb);
            do_op($sformatf("rnd%0d", i), ro, ra, rb, exp[2*W-1:W], exp[W-1:0], exp[2*W], model_lat(ro, rb));
        end

        // Stall holds a completed result; start is ignored until stall drops
        stall = 1'b1;
        issue(2'd1, 32'd3, 32'd4);
        wait_done(lat, bok);
        check("stall first lat", 64'(lat), 64'd3);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; op = 2'd1; a = $urandom; b = $urandom;
            @(negedge clk);
            $display("stall cycle %0d done=%0b hi=%h lo=%h", i, done, hi, lo);
            check("stall done", 64'(done), 64'd1);
            check("stall lo",   64'(lo),   64'd12);
            check("stall hi",   64'(hi),   64'd0);
        end
        stall = 1'b0;
        issue(2'd1, 32'd7, 32'd8);
        wait_done(lat, bok);
        $display("stall release op multu 7*8 -> lo=%h lat=%0d", lo, lat);
        check("release lat",  64'(lat), 64'd3);
        check("release busy", 64'(bok), 64'd1);
        check("release lo",   64'(lo),  64'd56);
        @(negedge clk);

        // Flush a divu mid-iteration; start asserted alongside is overridden
        issue(2'd3, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1; start = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        check("flush busy", 64'(busy), 64'd0);
        check("flush done", 64'(done), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        $display("flush divu 1000/3 -> activity_after=%0b hi=%h lo=%h", seen, hi, lo);
        check("flush no done", 64'(seen), 64'd0);
        check("flush hi", 64'(hi), 64'd0);
        check("flush lo", 64'(lo), 64'd56);

        // Reset in the middle of a multiply
        issue(2'd0, 32'hFFFFFFFD, 32'd7);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        $display("reset mid-mult -> busy=%0b done=%0b hi=%h lo=%h dbz=%0b", busy, done, hi, lo, div_by_zero);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst hi",   64'(hi),   64'd0);
        check("midrst lo",   64'(lo),   64'd0);
        check("midrst dbz",  64'(div_by_zero), 64'd0);
        do_op("post_rst", 2'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
